// File: rtl/spi_pkg.sv
`default_nettype none
//==============================================================================
// Package  : spi_pkg
// Brief    : Shared SPI definitions: mode decode helpers and the slave FSM
//            state encoding. The master uses the same mode decode.
// Revision : 1.0 - initial release
//==============================================================================
package spi_pkg;

  // Slave frame-tracking states
  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ACTIVE   = 2'd2
  } spi_state_t;

  // Clock polarity: idle level of SCLK
  function automatic logic spi_cpol(input int mode);
    return mode[1];
  endfunction

  // Clock phase: 0 samples on the leading edge, 1 on the trailing edge
  function automatic logic spi_cpha(input int mode);
    return mode[0];
  endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_input_sync.sv
`default_nettype none
//==============================================================================
// Module   : spi_input_sync
// Brief    : Two-flop synchroniser for an asynchronous pin followed by one
//            history flop, giving the synced level plus rise/fall events.
// Revision : 1.0 - initial release
//==============================================================================
module spi_input_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Pin,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability filter plus one stage of history for edge detection
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_Pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_Level = r_sync;
  assign o_Rise  = r_sync & ~r_prev;
  assign o_Fall  = ~r_sync & r_prev;

endmodule : spi_input_sync
`default_nettype wire

// File: rtl/spi_slave_with_single_cs.sv
`default_nettype none
//==============================================================================
// Module   : spi_slave_with_single_cs
// Brief    : SPI slave endpoint. Oversamples SCLK/CS_n/MOSI on i_Clk,
//            deserialises MOSI into bytes, serialises a user byte stream onto
//            MISO through a one-deep holding register, counts bytes per frame.
// Revision : 1.0 - initial release
//==============================================================================
module spi_slave_with_single_cs
  import spi_pkg::*;
#(
  parameter int         SPI_MODE         = 0,
  parameter int         MAX_BYTES_PER_CS = 4,
  parameter logic [7:0] TX_DEFAULT       = 8'h00
) (
  input  logic                                  i_Clk,
  input  logic                                  i_Rst_L,
  input  logic [7:0]                            i_TX_Byte,
  input  logic                                  i_TX_DV,
  output logic                                  o_TX_Ready,
  output logic                                  o_TX_Underrun,
  output logic                                  o_RX_DV,
  output logic [7:0]                            o_RX_Byte,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_RX_Count,
  output logic                                  o_CS_Start,
  output logic                                  o_CS_End,
  input  logic                                  i_SPI_Clk,
  input  logic                                  i_SPI_CS_n,
  input  logic                                  i_SPI_MOSI,
  output logic                                  o_SPI_MISO,
  output logic                                  o_SPI_MISO_En
);

  localparam logic                c_CPOL    = spi_cpol(SPI_MODE);
  localparam logic                c_CPHA    = spi_cpha(SPI_MODE);
  localparam int                  c_CNT_W   = $clog2(MAX_BYTES_PER_CS + 1);
  localparam logic [c_CNT_W-1:0]  c_MAX_CNT = c_CNT_W'(MAX_BYTES_PER_CS);

  // ---------------------------------------------------------------------------
  // Pin synchronisers
  // ---------------------------------------------------------------------------
  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_cs_level,   w_cs_rise,   w_cs_fall;
  logic w_mosi_level, w_mosi_rise, w_mosi_fall;

  spi_input_sync #(.RESET_VAL(c_CPOL)) u_sync_sclk (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Pin   (i_SPI_Clk),
    .o_Level (w_sclk_level),
    .o_Rise  (w_sclk_rise),
    .o_Fall  (w_sclk_fall)
  );

  spi_input_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Pin   (i_SPI_CS_n),
    .o_Level (w_cs_level),
    .o_Rise  (w_cs_rise),
    .o_Fall  (w_cs_fall)
  );

  spi_input_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Pin   (i_SPI_MOSI),
    .o_Level (w_mosi_level),
    .o_Rise  (w_mosi_rise),
    .o_Fall  (w_mosi_fall)
  );

  // Only edges of SCLK and the level of MOSI matter to this block
  logic w_unused_sync;
  assign w_unused_sync = w_sclk_level ^ w_mosi_rise ^ w_mosi_fall;

  // ---------------------------------------------------------------------------
  // Edge classification
  // ---------------------------------------------------------------------------
  logic w_lead, w_trail, w_sample, w_shift;
  assign w_lead   = c_CPOL ? w_sclk_fall : w_sclk_rise;
  assign w_trail  = c_CPOL ? w_sclk_rise : w_sclk_fall;
  assign w_sample = c_CPHA ? w_trail : w_lead;
  assign w_shift  = c_CPHA ? w_lead  : w_trail;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  spi_state_t          r_state;
  logic [1:0]          r_arm_cnt;
  logic [2:0]          r_bit_cnt;
  logic [c_CNT_W-1:0]  r_byte_cnt;
  logic [6:0]          r_rx_shift;
  logic [7:0]          r_tx_shift;
  logic [7:0]          r_hold;
  logic                r_cs_end_dly;

  logic                w_active;
  logic                w_frame_start;
  logic                w_tx_load;
  logic                w_byte_done;
  logic [c_CNT_W-1:0]  w_next_cnt;

  assign w_active      = (r_state == ST_ACTIVE);
  assign w_frame_start = (r_state == ST_IDLE) && w_cs_fall;
  // The bit counter sits at 0 exactly on the shift edge that opens each byte,
  // so one rule covers both phases; CPHA=0 additionally preloads at CS fall.
  assign w_tx_load     = (w_frame_start && !c_CPHA) ||
                         (w_active && w_shift && (r_bit_cnt == 3'd0) && !w_cs_rise);
  assign w_byte_done   = w_active && w_sample && (r_bit_cnt == 3'd7);
  assign w_next_cnt    = (r_byte_cnt >= c_MAX_CNT) ? c_MAX_CNT
                                                   : r_byte_cnt + c_CNT_W'(1);

  assign o_SPI_MISO = o_SPI_MISO_En & r_tx_shift[7];

  // Frame FSM, shift registers, holding register and all registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state       <= ST_DISARMED;
      r_arm_cnt     <= 2'd0;
      r_bit_cnt     <= 3'd0;
      r_byte_cnt    <= '0;
      r_rx_shift    <= 7'd0;
      r_tx_shift    <= 8'd0;
      r_hold        <= 8'd0;
      r_cs_end_dly  <= 1'b0;
      o_TX_Ready    <= 1'b1;
      o_TX_Underrun <= 1'b0;
      o_RX_DV       <= 1'b0;
      o_RX_Byte     <= 8'd0;
      o_RX_Count    <= '0;
      o_CS_Start    <= 1'b0;
      o_CS_End      <= 1'b0;
      o_SPI_MISO_En <= 1'b0;
    end else begin
      o_RX_DV       <= 1'b0;
      o_CS_Start    <= 1'b0;
      o_TX_Underrun <= 1'b0;
      o_CS_End      <= r_cs_end_dly;
      r_cs_end_dly  <= 1'b0;

      case (r_state)
        // The synchronisers reset to "CS high", so demand three consecutive
        // high observations before arming; this flushes the reset value and
        // keeps a CS held low through reset from looking like a new frame.
        ST_DISARMED: begin
          if (w_cs_level) begin
            if (r_arm_cnt == 2'd2) begin
              r_state   <= ST_IDLE;
              r_arm_cnt <= 2'd0;
            end else begin
              r_arm_cnt <= r_arm_cnt + 2'd1;
            end
          end else begin
            r_arm_cnt <= 2'd0;
          end
        end

        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state       <= ST_ACTIVE;
            o_CS_Start    <= 1'b1;
            r_bit_cnt     <= 3'd0;
            r_byte_cnt    <= '0;
            o_SPI_MISO_En <= 1'b1;
          end
        end

        ST_ACTIVE: begin
          if (w_sample) begin
            r_rx_shift <= {r_rx_shift[5:0], w_mosi_level};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              o_RX_DV    <= 1'b1;
              o_RX_Byte  <= {r_rx_shift, w_mosi_level};
              o_RX_Count <= w_next_cnt;
              r_byte_cnt <= w_next_cnt;
            end
          end
          if (w_cs_rise) begin
            r_state       <= ST_IDLE;
            o_SPI_MISO_En <= 1'b0;
            // A byte completing on the CS-rise cycle is reported first
            if (w_byte_done) begin
              r_cs_end_dly <= 1'b1;
            end else begin
              o_CS_End <= 1'b1;
            end
          end else if (w_shift) begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end
        end

        default: r_state <= ST_DISARMED;
      endcase

      // Load overrides the plain shift above
      if (w_tx_load) begin
        if (!o_TX_Ready) begin
          r_tx_shift <= r_hold;
          o_TX_Ready <= 1'b1;
        end else begin
          r_tx_shift    <= TX_DEFAULT;
          o_TX_Underrun <= 1'b1;
        end
      end

      // A write is taken only into an empty holding register; one arriving
      // with an underrun load lands here for the next load.
      if (i_TX_DV && o_TX_Ready) begin
        r_hold     <= i_TX_Byte;
        o_TX_Ready <= 1'b0;
      end
    end
  end

endmodule : spi_slave_with_single_cs
`default_nettype wire

// File: tb/tb_spi_slave_with_single_cs.sv
`default_nettype none
//==============================================================================
// Module   : tb_spi_slave_with_single_cs
// Brief    : Directed bench: a mode-3 and a mode-0 slave driven by a
//            behavioural SPI master with hand-computed expected bytes.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
module tb_spi_slave_with_single_cs;

  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sclk = 1'b1;
  logic mosi = 1'b0;
  logic cs3_n = 1'b1;
  logic cs0_n = 1'b1;

  logic [7:0] tx_byte3 = 8'h00;
  logic       tx_dv3 = 1'b0;
  logic       ready3, und3, rxdv3, start3, end3, miso3, en3;
  logic [7:0] rxbyte3;
  logic [2:0] rxcnt3;

  logic [7:0] tx_byte0 = 8'h00;
  logic       tx_dv0 = 1'b0;
  logic       ready0, und0, rxdv0, start0, end0, miso0, en0;
  logic [7:0] rxbyte0;
  logic [2:0] rxcnt0;

  always #5 clk = ~clk;

  spi_slave_with_single_cs #(.SPI_MODE(3), .MAX_BYTES_PER_CS(4), .TX_DEFAULT(8'h00)) u_dut3 (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_TX_Byte(tx_byte3), .i_TX_DV(tx_dv3), .o_TX_Ready(ready3), .o_TX_Underrun(und3),
    .o_RX_DV(rxdv3), .o_RX_Byte(rxbyte3), .o_RX_Count(rxcnt3),
    .o_CS_Start(start3), .o_CS_End(end3),
    .i_SPI_Clk(sclk), .i_SPI_CS_n(cs3_n), .i_SPI_MOSI(mosi),
    .o_SPI_MISO(miso3), .o_SPI_MISO_En(en3)
  );

  spi_slave_with_single_cs #(.SPI_MODE(0), .MAX_BYTES_PER_CS(4), .TX_DEFAULT(8'h00)) u_dut0 (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_TX_Byte(tx_byte0), .i_TX_DV(tx_dv0), .o_TX_Ready(ready0), .o_TX_Underrun(und0),
    .o_RX_DV(rxdv0), .o_RX_Byte(rxbyte0), .o_RX_Count(rxcnt0),
    .o_CS_Start(start0), .o_CS_End(end0),
    .i_SPI_Clk(sclk), .i_SPI_CS_n(cs0_n), .i_SPI_MOSI(mosi),
    .o_SPI_MISO(miso0), .o_SPI_MISO_En(en0)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitors, sampled on the falling clock edge
  logic [7:0] rx3_q[$];
  logic [2:0] rxc3_q[$];
  logic [7:0] rx0_q[$];
  logic [2:0] rxc0_q[$];
  int start3_n = 0, end3_n = 0, und3_n = 0;

  always @(negedge clk) begin
    if (rxdv3) begin rx3_q.push_back(rxbyte3); rxc3_q.push_back(rxcnt3); end
    if (rxdv0) begin rx0_q.push_back(rxbyte0); rxc0_q.push_back(rxcnt0); end
    if (start3) start3_n++;
    if (end3)   end3_n++;
    if (und3)   und3_n++;
  end

  function automatic logic [7:0] rx3_at(input int k);
    if (k < rx3_q.size()) return rx3_q[k];
    return 8'hxx;
  endfunction

  function automatic logic [2:0] rxc3_at(input int k);
    if (k < rxc3_q.size()) return rxc3_q[k];
    return 3'bxxx;
  endfunction

  // Holding-register feeder for the mode-3 slave: bit 8 forces a write
  // even when the slave is not ready.
  logic [8:0] feed_q[$];
  logic [8:0] feed_ent;
  always @(negedge clk) begin
    tx_dv3 = 1'b0;
    if (feed_q.size() > 0 && (ready3 || feed_q[0][8])) begin
      feed_ent = feed_q.pop_front();
      tx_byte3 = feed_ent[7:0];
      tx_dv3   = 1'b1;
    end
  end

  // One byte (or nbits of it) as a behavioural SPI master, mode 0 or 3
  task automatic spi_byte(input int sel, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    logic pol;
    pol = (sel == 3);
    rx  = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (sel == 0) begin
        mosi = tx[i];
        repeat (HALF) @(negedge clk);
        rx[i] = miso0;
        sclk  = ~pol;
        repeat (HALF) @(negedge clk);
        sclk  = pol;
      end else begin
        sclk = ~pol;
        mosi = tx[i];
        repeat (HALF) @(negedge clk);
        rx[i] = miso3;
        sclk  = pol;
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  logic [7:0] mrx [4];

  // Mode-3 frame: bytes packed MSB-first in 'bytes'; last byte may be partial
  task automatic frame3(input int nb, input logic [31:0] bytes, input int last_bits);
    logic [7:0] r;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    cs3_n = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    for (int k = 0; k < nb; k++) begin
      spi_byte(3, bytes[31 - 8 * k -: 8], (k == nb - 1) ? last_bits : 8, r);
      mrx[k] = r;
    end
    repeat (HALF) @(negedge clk);
    cs3_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  int b_rx, b_st, b_en, b_un;
  task automatic snap();
    b_rx = rx3_q.size();
    b_st = start3_n;
    b_en = end3_n;
    b_un = und3_n;
  endtask

  logic [7:0] r0;

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk_eq("rst_ready",  32'(ready3), 32'd1);
    chk_eq("rst_rxdv",   32'(rxdv3), 32'd0);
    chk_eq("rst_rxbyte", 32'(rxbyte3), 32'd0);
    chk_eq("rst_rxcnt",  32'(rxcnt3), 32'd0);
    chk_eq("rst_misoen", 32'(en3), 32'd0);
    chk_eq("rst_miso",   32'(miso3), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Mode-3 four-byte loopback
    snap();
    feed_q.push_back(9'h0A5); feed_q.push_back(9'h05A);
    feed_q.push_back(9'h03C); feed_q.push_back(9'h0C3);
    frame3(4, 32'hC1C2C3C4, 8);
    chk_eq("lb_mrx0", 32'(mrx[0]), 32'hA5);
    chk_eq("lb_mrx1", 32'(mrx[1]), 32'h5A);
    chk_eq("lb_mrx2", 32'(mrx[2]), 32'h3C);
    chk_eq("lb_mrx3", 32'(mrx[3]), 32'hC3);
    chk_eq("lb_nrx",  32'(rx3_q.size() - b_rx), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk_eq($sformatf("lb_srx%0d", k), 32'(rx3_at(b_rx + k)), 32'(8'hC1 + k));
      chk_eq($sformatf("lb_cnt%0d", k), 32'(rxc3_at(b_rx + k)), 32'(k + 1));
    end
    chk_eq("lb_start", 32'(start3_n - b_st), 32'd1);
    chk_eq("lb_end",   32'(end3_n - b_en), 32'd1);
    chk_eq("lb_und",   32'(und3_n - b_un), 32'd0);
    chk_eq("lb_en",    32'(en3), 32'd0);

    // Mode-0 single byte with MISO valid before the first SCLK edge
    tx_byte0 = 8'h81; tx_dv0 = 1'b1;
    @(negedge clk);
    tx_dv0 = 1'b0;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    b_rx = rx0_q.size();
    cs0_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("m0_miso_early", 32'(miso0), 32'd1);
    chk_eq("m0_en_early",   32'(en0), 32'd1);
    @(negedge clk);
    repeat (HALF) @(negedge clk);
    spi_byte(0, 8'h96, 8, r0);
    repeat (HALF) @(negedge clk);
    cs0_n = 1'b1;
    repeat (12) @(negedge clk);
    chk_eq("m0_mrx", 32'(r0), 32'h81);
    chk_eq("m0_nrx", 32'(rx0_q.size() - b_rx), 32'd1);
    if (rx0_q.size() > b_rx) begin
      chk_eq("m0_srx", 32'(rx0_q[b_rx]), 32'h96);
      chk_eq("m0_cnt", 32'(rxc0_q[b_rx]), 32'd1);
    end

    // Underrun on the second byte
    snap();
    feed_q.push_back(9'h011);
    frame3(2, 32'h01020000, 8);
    chk_eq("ur_mrx0", 32'(mrx[0]), 32'h11);
    chk_eq("ur_mrx1", 32'(mrx[1]), 32'h00);
    chk_eq("ur_und",  32'(und3_n - b_un), 32'd1);
    chk_eq("ur_srx1", 32'(rx3_at(b_rx + 1)), 32'h02);
    chk_eq("ur_cnt1", 32'(rxc3_at(b_rx + 1)), 32'd2);

    // Abort after five bits of the second byte, then a clean frame
    snap();
    feed_q.push_back(9'h022); feed_q.push_back(9'h033);
    frame3(2, 32'h5CFF0000, 5);
    chk_eq("ab_mrx0", 32'(mrx[0]), 32'h22);
    chk_eq("ab_nrx",  32'(rx3_q.size() - b_rx), 32'd1);
    chk_eq("ab_srx",  32'(rx3_at(b_rx)), 32'h5C);
    chk_eq("ab_end",  32'(end3_n - b_en), 32'd1);
    chk_eq("ab_en",   32'(en3), 32'd0);
    snap();
    feed_q.push_back(9'h044);
    frame3(1, 32'h7E000000, 8);
    chk_eq("ab2_mrx", 32'(mrx[0]), 32'h44);
    chk_eq("ab2_srx", 32'(rx3_at(b_rx)), 32'h7E);
    chk_eq("ab2_cnt", 32'(rxc3_at(b_rx)), 32'd1);

    // Write while not ready is dropped
    feed_q.push_back(9'h0AB); feed_q.push_back(9'h1EE);
    repeat (6) @(negedge clk);
    chk_eq("hs_ready_lo", 32'(ready3), 32'd0);
    snap();
    frame3(1, 32'h0F000000, 8);
    chk_eq("hs_mrx",      32'(mrx[0]), 32'hAB);
    chk_eq("hs_srx",      32'(rx3_at(b_rx)), 32'h0F);
    chk_eq("hs_ready_hi", 32'(ready3), 32'd1);

    // Reset mid-byte with CS held low
    feed_q.push_back(9'h055);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    cs3_n = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    spi_byte(3, 8'hF0, 3, r0);
    #3 rst_n = 1'b0;
    #1;
    chk_eq("mr_en",    32'(en3), 32'd0);
    chk_eq("mr_ready", 32'(ready3), 32'd1);
    chk_eq("mr_rxcnt", 32'(rxcnt3), 32'd0);
    repeat (3) @(negedge clk);
    snap();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_eq("mr_nostart", 32'(start3_n - b_st), 32'd0);
    chk_eq("mr_en_off",  32'(en3), 32'd0);
    cs3_n = 1'b1;
    repeat (10) @(negedge clk);
    snap();
    feed_q.push_back(9'h066);
    frame3(1, 32'h99000000, 8);
    chk_eq("mr_mrx",   32'(mrx[0]), 32'h66);
    chk_eq("mr_srx",   32'(rx3_at(b_rx)), 32'h99);
    chk_eq("mr_cnt",   32'(rxc3_at(b_rx)), 32'd1);
    chk_eq("mr_start", 32'(start3_n - b_st), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_spi_slave_with_single_cs
`default_nettype wire

// File: doc/spi_slave_with_single_cs.md
Name: spi_slave_with_single_cs

Overview:
SPI peripheral (slave) endpoint and counterpart of the team's single-CS SPI master. It oversamples SPI_Clk, CS_n and MOSI on the system clock, deserialises MOSI into bytes and serialises a user-supplied byte stream onto MISO. It counts bytes per chip-select frame. It sits between FPGA pins and user logic and uses the same byte handshake style as the master.

Parameters:
SPI_MODE, 0, CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]
MAX_BYTES_PER_CS, 4, o_RX_Count saturates at this value
TX_DEFAULT, 8'h00, byte shifted out when the holding register is empty (underrun)

Ports:
i_Clk  in  1  system clock; every SPI input is sampled on it
i_Rst_L  in  1  asynchronous active-low reset
i_TX_Byte  in  8  next byte to send on MISO
i_TX_DV  in  1  1-cycle write strobe for i_TX_Byte
o_TX_Ready  out  1  holding register empty; a write is accepted
o_TX_Underrun  out  1  1-cycle pulse: TX_DEFAULT loaded because the holding register was empty
o_RX_DV  out  1  1-cycle pulse: o_RX_Byte is valid
o_RX_Byte  out  8  received byte, MSB first
o_RX_Count  out  $clog2(MAX_BYTES_PER_CS+1)  bytes received in the current frame, including this one
o_CS_Start  out  1  1-cycle pulse at frame start
o_CS_End  out  1  1-cycle pulse at frame end
i_SPI_Clk  in  1  SPI clock from the master
i_SPI_CS_n  in  1  chip select, active low
i_SPI_MOSI  in  1  master-out data
o_SPI_MISO  out  1  slave-out data; 0 when not enabled
o_SPI_MISO_En  out  1  tri-state enable for the MISO pad

Behaviour:
- Sync stage: 2-flop synchronisers on SCLK, CS_n and MOSI. Reset values are CPOL, 1 and 0.
- Edge detect: one further register on each synced signal. Latency from a pin edge to the internal event is 3 i_Clk cycles. The SPI clock must be no faster than i_Clk/8 (master CLKS_PER_HALF_BIT >= 4).
- Edge definitions: leading edge = SCLK leaving CPOL; trailing edge = SCLK returning to CPOL.
- Sampling: CPHA=0 samples MOSI on leading edges and shifts MISO on trailing edges. CPHA=1 is the reverse.
- Reset values: all outputs 0 except o_TX_Ready=1. Shift registers and counters clear. FSM goes to DISARMED.
- FSM state DISARMED: leaves for IDLE once synced CS_n=1. A CS held low through reset release never starts a frame.
- FSM state IDLE: on a synced CS_n falling edge go to ACTIVE, pulse o_CS_Start, clear bit_cnt and byte_cnt, assert MISO_En.
  - If CPHA=0, also load the TX shift register at this point (see TX load), so MISO already carries bit 7.
- FSM state ACTIVE: on each sample edge, shift in the MOSI bit and increment bit_cnt (3 bits, wraps at 8).
  - When the 8th bit is sampled, on the next cycle: o_RX_DV=1, o_RX_Byte=the byte, o_RX_Count=min(byte_cnt+1, MAX_BYTES_PER_CS).
- TX load event:
  - CPHA=0: at frame start, and on the trailing edge after each 8th sample.
  - CPHA=1: on the leading edge where bit_cnt==0.
  - All other shift edges shift the register left. o_SPI_MISO = tx_shift[7] while enabled.
- TX load source: the holding register if full; it empties and o_TX_Ready rises the next cycle. If empty: load TX_DEFAULT and pulse o_TX_Underrun.
- Holding-register handshake:
  - i_TX_DV with o_TX_Ready=1: capture i_TX_Byte; o_TX_Ready=0 the next cycle.
  - i_TX_DV with o_TX_Ready=0: ignored; the data is dropped.
  - i_TX_DV on the same cycle as a load from an empty register: the load takes TX_DEFAULT and the write is captured for the next load.
- CS rise in ACTIVE: go to IDLE, pulse o_CS_End, deassert MISO_En, force MISO to 0. A partial byte is discarded with no RX_DV. An unconsumed holding register is retained.
- CS rise on the same cycle as the 8th sample: the byte is delivered (o_RX_DV), then o_CS_End pulses.
- Asynchronous reset mid-frame: immediate return to reset values and DISARMED. The current frame is lost.

Decomposition:
- Package spi_pkg: SPI mode decode functions (cpol/cpha from SPI_MODE) and the FSM state enum (DISARMED, IDLE, ACTIVE). The master reuses the mode decode.
- Sub-module spi_input_sync: a 3-flop synchroniser with rise/fall detect, instantiated once each for SCLK, CS_n and MOSI. It has a reset-value parameter.

Test Plan:
- Mode 3 loopback against SPI_Master_With_Single_CS (CLKS_PER_HALF_BIT=4, MAX_BYTES_PER_CS=4). Master sends C1..C4; slave is preloaded A5, 5A, 3C, C3 one per o_TX_Ready.
  - Expect slave RX C1..C4 with o_RX_Count 1..4.
  - Expect master RX A5, 5A, 3C, C3.
  - Expect one o_CS_Start and one o_CS_End.
- Mode 0, single byte 96, slave preloaded 81: MISO=1 within 3 clk of the CS fall, before the first SCLK edge. Master RX 81; slave RX 96.
- Underrun: 2-byte frame with only 11 preloaded. Byte 2 on MISO is TX_DEFAULT=00 and o_TX_Underrun pulses once.
- Abort: CS raised after 5 bits of byte 2. Only one o_RX_DV; o_CS_End pulses; MISO_En=0. The next frame's RX is clean.
- Handshake: a second i_TX_DV (byte EE) while o_TX_Ready=0 is ignored; the slave transmits the first byte.
- Reset pulse mid-byte with CS held low: outputs return to reset values, no o_CS_Start until CS goes high then low, and the next frame works normally.
